// File: rtl/aes_pkg.sv
// Shared Rijndael helpers for the ShiftRows pipeline: byte type, legal block
// widths and the per-row rotate amount.
package aes_pkg;

  typedef logic [7:0] byte_t;

  // Bit n set when NB = n is a supported block width (4, 6, 8).
  localparam logic [8:0] NB_LEGAL = 9'b1_0101_0000;

  function automatic logic nb_legal(int unsigned nb);
    logic [3:0] idx;
    idx = nb[3:0];
    return (nb <= 32'd8) && NB_LEGAL[idx];
  endfunction

  // Rows 2 and 3 rotate one extra position for the 256-bit block.
  function automatic int unsigned shift_amt(int unsigned nb, int unsigned row);
    int unsigned amt;
    amt = row;
    if ((nb == 32'd8) && (row >= 32'd2)) begin
      amt = row + 32'd1;
    end
    return amt;
  endfunction

endpackage

// File: rtl/sr_permute.sv
// Combinational ShiftRows / InvShiftRows byte permutation over NB columns;
// byte 0 is in the MSBs and bytes are packed column-major.
module sr_permute
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic              dec,
  input  logic [32*NB-1:0]  state,
  output logic [32*NB-1:0]  shifted_c
);

  localparam int unsigned W = 32 * NB;

  // Each destination byte picks from a fixed forward or inverse source byte.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned SH  = shift_amt(NB, r);
      localparam int unsigned DST = r + 4 * c;
      localparam int unsigned FWD = r + 4 * ((c + SH) % NB);
      localparam int unsigned INV = r + 4 * ((c + NB - SH) % NB);

      byte_t fwd_b;
      byte_t inv_b;

      assign fwd_b = state[W-1-8*FWD -: 8];
      assign inv_b = state[W-1-8*INV -: 8];
      assign shifted_c[W-1-8*DST -: 8] = dec ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/shiftrows_pipe.sv
// Registered ShiftRows / InvShiftRows stage with valid/ready skid buffering.
// Optional performance counters enabled by SHIFTROWS_PIPE_PERF_EN.
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dec,
  input  logic [32*NB-1:0]  in_state,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHIFTROWS_PIPE_PERF_EN
  ,
  output logic [31:0]       beat_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shiftrows_pipe: TAG_W must be at least 1");
  end

  logic [W-1:0]     perm_c;
  logic             main_valid;
  logic             skid_valid;
  logic [W-1:0]     skid_state;
  logic [TAG_W-1:0] skid_tag;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic             load_main_c;

  sr_permute #(.NB(NB)) u_perm (
    .dec       (in_dec),
    .state     (in_state),
    .shifted_c (perm_c)
  );

  assign in_xfer_c   = in_valid && !skid_valid;
  assign out_xfer_c  = main_valid && out_ready;
  assign load_main_c = !main_valid || out_ready;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;

  // Main register refills from skid first so beats keep acceptance order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      out_state  <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_state <= '0;
      skid_tag   <= '0;
    end else if (load_main_c) begin
      if (skid_valid) begin
        out_state  <= skid_state;
        out_tag    <= skid_tag;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer_c) begin
        out_state  <= perm_c;
        out_tag    <= in_tag;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer_c) begin
      skid_state <= perm_c;
      skid_tag   <= in_tag;
      skid_valid <= 1'b1;
    end
  end

`ifdef SHIFTROWS_PIPE_PERF_EN
  // Free-running transfer and stall counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (out_xfer_c) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (main_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_c;
  assign unused_c = out_xfer_c;
`endif

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Directed self-checking bench for shiftrows_pipe (NB=4 and NB=8 instances).
`timescale 1ns/1ps
module tb_shiftrows_pipe;

  localparam logic [127:0] VEC4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FWD4 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] INV4 = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [255:0] VEC8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FWD8 =
    256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_dec, out_valid, out_ready;
  logic [127:0] in_state, out_state;
  logic [3:0]   in_tag, out_tag;

  logic         b_in_valid, b_in_ready, b_in_dec, b_out_valid, b_out_ready;
  logic [255:0] b_in_state, b_out_state;
  logic [3:0]   b_in_tag, b_out_tag;

`ifdef SHIFTROWS_PIPE_PERF_EN
  logic [31:0] beat_cnt, stall_cnt, b_beat_cnt, b_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shiftrows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_state(in_state), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag)
`ifdef SHIFTROWS_PIPE_PERF_EN
    , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  shiftrows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dec(b_in_dec),
    .in_state(b_in_state), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_state(b_out_state), .out_tag(b_out_tag)
`ifdef SHIFTROWS_PIPE_PERF_EN
    , .beat_cnt(b_beat_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h expected 0", out_state); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_nb8_valid: got %b expected 0", b_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_dec = 1'b0; in_state = VEC4; in_tag = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b expected 1", out_valid); end
    checks++; if (out_state !== FWD4) begin errors++; $display("FAIL fwd_state: got %h expected %h", out_state, FWD4); end
    checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL fwd_tag: got %h expected 5", out_tag); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_inverse();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_dec = 1'b1; in_state = VEC4; in_tag = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_state !== INV4) begin errors++; $display("FAIL inv_state: got %h expected %h", out_state, INV4); end
    checks++; if (out_tag !== 4'h6) begin errors++; $display("FAIL inv_tag: got %h expected 6", out_tag); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_dec = 1'b0; in_state = VEC4; in_tag = 4'h1;
    @(negedge clk);
    checks++; if (out_state !== FWD4) begin errors++; $display("FAIL b2b_fwd_state: got %h expected %h", out_state, FWD4); end
    checks++; if (out_tag !== 4'h1) begin errors++; $display("FAIL b2b_fwd_tag: got %h expected 1", out_tag); end
    in_dec = 1'b1; in_state = FWD4; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_inv_valid: got %b expected 1", out_valid); end
    checks++; if (out_state !== VEC4) begin errors++; $display("FAIL b2b_roundtrip_state: got %h expected %h", out_state, VEC4); end
    checks++; if (out_tag !== 4'h2) begin errors++; $display("FAIL b2b_inv_tag: got %h expected 2", out_tag); end
    @(negedge clk);
  endtask

  task automatic test_nb8();
    @(negedge clk);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_dec = 1'b0; b_in_state = VEC8; b_in_tag = 4'h3;
    @(negedge clk);
    checks++; if (b_out_state !== FWD8) begin errors++; $display("FAIL nb8_fwd_state: got %h expected %h", b_out_state, FWD8); end
    checks++; if (b_out_state[255:224] !== 32'h00050e13) begin errors++; $display("FAIL nb8_col0: got %h expected 00050e13", b_out_state[255:224]); end
    checks++; if (b_out_tag !== 4'h3) begin errors++; $display("FAIL nb8_fwd_tag: got %h expected 3", b_out_tag); end
    b_in_dec = 1'b1; b_in_state = FWD8; b_in_tag = 4'h4;
    @(negedge clk);
    b_in_valid = 1'b0;
    checks++; if (b_out_state !== VEC8) begin errors++; $display("FAIL nb8_inv_state: got %h expected %h", b_out_state, VEC8); end
    checks++; if (b_out_tag !== 4'h4) begin errors++; $display("FAIL nb8_inv_tag: got %h expected 4", b_out_tag); end
  endtask

  task automatic test_backpressure();
    int next_tag = 1;
    int rx = 0;
    int acc_at_drop = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      if (out_valid && !out_ready) begin
        checks++; if (out_tag !== 4'h1) begin errors++; $display("FAIL bp_stall_tag: got %h expected 1", out_tag); end
        checks++; if (out_state !== FWD4) begin errors++; $display("FAIL bp_stall_state: got %h expected %h", out_state, FWD4); end
      end
      if (out_valid && out_ready) begin
        checks++; if (out_tag !== 4'(rx + 1)) begin errors++; $display("FAIL bp_order: got %h expected %h", out_tag, 4'(rx + 1)); end
        rx++;
      end
      if (!in_ready && acc_at_drop < 0) acc_at_drop = next_tag - 1;
      if (next_tag <= 4) begin
        in_valid = 1'b1; in_dec = 1'b0; in_state = VEC4; in_tag = 4'(next_tag);
        if (in_ready) next_tag++;
      end else begin
        in_valid = 1'b0;
      end
      if (rx == 4) break;
    end
    in_valid = 1'b0;
    checks++; if (rx !== 4) begin errors++; $display("FAIL bp_delivered: got %0d expected 4 (timeout)", rx); end
    checks++; if (acc_at_drop !== 2) begin errors++; $display("FAIL bp_ready_drop: got %0d expected 2", acc_at_drop); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_skid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_dec = 1'b0; in_state = VEC4; in_tag = 4'h7;
    @(negedge clk);
    in_tag = 4'h8;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_skid_full: got %b expected 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL rst_async_state: got %h expected 0", out_state); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_async_tag: got %h expected 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_beat: got %b expected 0", out_valid); end
    end
  endtask

`ifdef SHIFTROWS_PIPE_PERF_EN
  task automatic test_perf();
    int sent = 0;
    logic done = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (sent < 10) begin
        in_valid = 1'b1; in_dec = 1'b0; in_state = VEC4; in_tag = 4'(sent + 1);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (!in_valid && !out_valid) begin done = 1'b1; break; end
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL perf_drain: got %b expected 1 (timeout)", done); end
    checks++; if (beat_cnt !== 32'd10) begin errors++; $display("FAIL perf_beat_cnt: got %0d expected 10", beat_cnt); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall_cnt: got %0d expected 3", stall_cnt); end
    @(negedge clk);
    force dut.beat_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.beat_cnt;
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL perf_wrap: got %h expected 0", beat_cnt); end
  endtask
`endif

  initial begin
    in_valid = 1'b0; in_dec = 1'b0; in_state = '0; in_tag = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_dec = 1'b0; b_in_state = '0; b_in_tag = '0; b_out_ready = 1'b1;
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_nb8();
    test_backpressure();
    test_reset_skid();
`ifdef SHIFTROWS_PIPE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
